atari_7800: RTL and testbench

- System bus decoder and cartridge mapper core of the Atari 7800 console.
- Sits between the 6502/Maria address bus and the memory/peripheral blocks.
- Decodes the CPU address into chip selects and maintains the INPTCTRL lock register.
- Translates addresses into cart ROM offsets for linear, SuperGame and 2600-mode (2K/4K/F8) carts.
- BIOS, cart ROM storage, CPU, Maria, TIA and RIOT are external.

---
 rtl/atari_7800_pkg.sv | 56 +++++
 rtl/atari_7800_cart_mapper.sv | 118 +++++++++++
 rtl/atari_7800.sv | 123 ++++++++++++
 tb/tb_atari_7800.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/atari_7800_pkg.sv
// ============================================================================
// Module   : atari_7800_pkg
// Brief    : Shared address map, INPTCTRL bit indices and cart mode type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package atari_7800_pkg;

    localparam logic [15:0] c_tia_lo      = 16'h0000;
    localparam logic [15:0] c_tia_hi      = 16'h001F;
    localparam logic [15:0] c_maria_lo    = 16'h0020;
    localparam logic [15:0] c_maria_hi    = 16'h003F;
    localparam logic [15:0] c_ram0_lo     = 16'h0040;
    localparam logic [15:0] c_ram0_hi     = 16'h00FF;
    localparam logic [15:0] c_ram1_lo     = 16'h0140;
    localparam logic [15:0] c_ram1_hi     = 16'h01FF;
    localparam logic [15:0] c_ram2_lo     = 16'h1800;
    localparam logic [15:0] c_ram2_hi     = 16'h27FF;
    localparam logic [15:0] c_riot0_lo    = 16'h0280;
    localparam logic [15:0] c_riot0_hi    = 16'h02FF;
    localparam logic [15:0] c_riot1_lo    = 16'h0480;
    localparam logic [15:0] c_riot1_hi    = 16'h04FF;
    localparam logic [15:0] c_bios_lo     = 16'hF000;
    localparam logic [15:0] c_hsc0_lo     = 16'h1000;
    localparam logic [15:0] c_hsc0_hi     = 16'h17FF;
    localparam logic [15:0] c_hsc1_lo     = 16'h3000;
    localparam logic [15:0] c_hsc1_hi     = 16'h3FFF;
    localparam logic [15:0] c_cart_lo     = 16'h4000;
    localparam logic [15:0] c_sg_lo       = 16'h8000;
    localparam logic [15:0] c_sg_hi       = 16'hBFFF;
    localparam logic [15:0] c_sg_fix_lo   = 16'hC000;

    localparam int c_inpt_lock  = 0;
    localparam int c_inpt_maria = 1;
    localparam int c_inpt_bios  = 2;
    localparam int c_inpt_tia   = 3;

    localparam logic [3:0] c_inpt_bypass = 4'b0110;

    typedef enum logic [1:0] {
        LINEAR    = 2'd0,
        SUPERGAME = 2'd1,
        A26_4K    = 2'd2,
        A26_F8    = 2'd3
    } cart_mode_e;

    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/atari_7800_cart_mapper.sv
// ============================================================================
// Module   : atari_7800_cart_mapper
// Brief    : Cart bank registers and CPU address to cart ROM offset mapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module atari_7800_cart_mapper
    import atari_7800_pkg::*;
#(
    parameter int CART_AW = 19
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [15:0]        AB,
    input  logic               RW,
    input  logic               cpu_ce,
    input  logic [3:0]         DB_in,
    input  logic               tia_mode,
    input  logic [31:0]        cart_size,
    input  logic [15:0]        cart_flags,
    output logic               cart_hit,
    output logic [CART_AW-1:0] cart_addr_out
);

    localparam int c_bank_w = CART_AW - 14;

    cart_mode_e         w_mode;
    logic [3:0]         bank_q, bank_d;
    logic               f8_bank_q, f8_bank_d;
    logic [CART_AW-1:0] addr_q, w_addr;
    logic               w_hit;
    logic [31:0]        w_lin_off, w_last, w_last_m1, w_mask;
    logic [12:0]        w_ab13;
    logic               w_sg_win;

    always_comb begin
        if (tia_mode) w_mode = (cart_size == 32'd8192) ? A26_F8 : A26_4K;
        else          w_mode = cart_flags[1] ? SUPERGAME : LINEAR;
    end

    // AB - ($10000 - size) rearranged so oversized linear carts wrap cleanly
    assign w_lin_off = {16'h0000, AB} + cart_size - 32'h0001_0000;
    assign w_last    = (cart_size >> 14) - 32'd1;
    assign w_last_m1 = w_last - 32'd1;
    assign w_mask    = cart_size - 32'd1;
    assign w_ab13    = AB[12:0];
    assign w_sg_win  = in_range(AB, c_sg_lo, c_sg_hi);

    always_comb begin
        w_hit  = 1'b0;
        w_addr = '0;
        case (w_mode)
            LINEAR: begin
                w_hit  = (AB >= c_cart_lo) &&
                         ((cart_size >= 32'h0001_0000) ||
                          ({16'h0000, AB} >= (32'h0001_0000 - cart_size)));
                w_addr = w_lin_off[CART_AW-1:0];
            end
            SUPERGAME: begin
                if (w_sg_win) begin
                    w_hit  = 1'b1;
                    w_addr = {{(c_bank_w-4){1'b0}}, bank_q, AB[13:0]};
                end else if (AB >= c_sg_fix_lo) begin
                    w_hit  = 1'b1;
                    w_addr = {w_last[c_bank_w-1:0], AB[13:0]};
                end else if ((AB >= c_cart_lo) && cart_flags[3]) begin
                    w_hit  = 1'b1;
                    w_addr = {w_last_m1[c_bank_w-1:0], AB[13:0]};
                end
            end
            A26_4K: begin
                w_hit  = w_ab13[12];
                w_addr = {{(CART_AW-12){1'b0}}, AB[11:0] & w_mask[11:0]};
            end
            A26_F8: begin
                w_hit  = w_ab13[12];
                w_addr = {{(CART_AW-13){1'b0}}, f8_bank_q, AB[11:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        bank_d    = bank_q;
        f8_bank_d = f8_bank_q;
        if (cpu_ce && !RW && (w_mode == SUPERGAME) && w_sg_win)
            bank_d = DB_in;
        // F8 hotspots switch on any access, read or write
        if (cpu_ce && (w_mode == A26_F8)) begin
            if (w_ab13 == 13'h1FF8)      f8_bank_d = 1'b0;
            else if (w_ab13 == 13'h1FF9) f8_bank_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bank_q    <= 4'd0;
            f8_bank_q <= 1'b1;
            addr_q    <= '0;
        end else begin
            bank_q    <= bank_d;
            f8_bank_q <= f8_bank_d;
            if (w_hit) addr_q <= w_addr;
        end
    end

    assign cart_hit      = w_hit;
    assign cart_addr_out = w_hit ? w_addr : addr_q;

    logic w_unused_ok;
    assign w_unused_ok = ^{cart_flags[15:4], cart_flags[2], cart_flags[0],
                           w_last[31:c_bank_w], w_last_m1[31:c_bank_w],
                           w_mask[31:12], w_lin_off[31:CART_AW]};

endmodule

`default_nettype wire

// File: rtl/atari_7800.sv
// ============================================================================
// Module   : atari_7800
// Brief    : Atari 7800 bus decoder, INPTCTRL lock register and cart mapper.
//            Optional high score cart decode under macro ATARI7800_HSC_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module atari_7800
    import atari_7800_pkg::*;
#(
    parameter int CART_AW = 19,
    parameter int BIOS_AW = 12
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [15:0]        AB,
    input  logic               RW,
    input  logic               cpu_ce,
    input  logic [7:0]         DB_in,
    input  logic               tia_mode,
    input  logic               bypass_bios,
    input  logic               hsc_en,
    input  logic [31:0]        cart_size,
    input  logic [15:0]        cart_flags,
    output logic               cart_sel,
    output logic [CART_AW-1:0] cart_addr_out,
    output logic               bios_sel,
    output logic               tia_sel,
    output logic               maria_sel,
    output logic               riot_sel,
    output logic               ram_sel,
    output logic               hsc_sel,
    output logic               tia_en,
    output logic               maria_en,
    output logic               locked
);

    logic [3:0] inpt_q, inpt_d;
    logic       w_cart_hit;
    logic       w_hsc_win, w_hsc_hit, w_bios_win;

    atari_7800_cart_mapper #(
        .CART_AW (CART_AW)
    ) u_mapper (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .AB            (AB),
        .RW            (RW),
        .cpu_ce        (cpu_ce),
        .DB_in         (DB_in[3:0]),
        .tia_mode      (tia_mode),
        .cart_size     (cart_size),
        .cart_flags    (cart_flags),
        .cart_hit      (w_cart_hit),
        .cart_addr_out (cart_addr_out)
    );

    always_comb begin
        inpt_d = inpt_q;
        if (cpu_ce && !RW && !inpt_q[c_inpt_lock] && in_range(AB, c_tia_lo, c_tia_hi))
            inpt_d = DB_in[3:0];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) inpt_q <= bypass_bios ? c_inpt_bypass : 4'b0000;
        else          inpt_q <= inpt_d;
    end

    assign tia_en   = tia_mode | inpt_q[c_inpt_tia];
    assign maria_en = ~tia_mode & inpt_q[c_inpt_maria];
    assign locked   = inpt_q[c_inpt_lock];

    assign w_hsc_win  = in_range(AB, c_hsc0_lo, c_hsc0_hi) || in_range(AB, c_hsc1_lo, c_hsc1_hi);
    assign w_bios_win = (AB >= c_bios_lo) && (AB[15:BIOS_AW] == '1);

`ifdef ATARI7800_HSC_EN
    assign w_hsc_hit = hsc_en & w_hsc_win;
`else
    assign w_hsc_hit = 1'b0;
    logic w_unused_hsc;
    assign w_unused_hsc = hsc_en ^ w_hsc_win;
`endif

    always_comb begin
        tia_sel   = 1'b0;
        maria_sel = 1'b0;
        ram_sel   = 1'b0;
        riot_sel  = 1'b0;
        bios_sel  = 1'b0;
        hsc_sel   = 1'b0;
        cart_sel  = 1'b0;
        if (tia_mode) begin
            // 13-bit 2600 bus: A12 picks the cart, A9/A7 split TIA/RAM/RIOT
            if (AB[12])                  cart_sel = 1'b1;
            else if (!AB[7])             tia_sel  = 1'b1;
            else if (AB[9:7] == 3'b001)  ram_sel  = 1'b1;
            else if (AB[9] && AB[7])     riot_sel = 1'b1;
        end else begin
            if (in_range(AB, c_tia_lo, c_tia_hi))
                tia_sel = 1'b1;
            else if (in_range(AB, c_maria_lo, c_maria_hi))
                maria_sel = 1'b1;
            else if (in_range(AB, c_ram0_lo, c_ram0_hi) || in_range(AB, c_ram1_lo, c_ram1_hi) ||
                     in_range(AB, c_ram2_lo, c_ram2_hi))
                ram_sel = 1'b1;
            else if (in_range(AB, c_riot0_lo, c_riot0_hi) || in_range(AB, c_riot1_lo, c_riot1_hi))
                riot_sel = 1'b1;
            else if (w_bios_win && !inpt_q[c_inpt_bios])
                bios_sel = 1'b1;
            else if (w_hsc_hit)
                hsc_sel = 1'b1;
            else if ((AB >= c_cart_lo) && w_cart_hit)
                cart_sel = 1'b1;
        end
    end

    logic w_unused_ok;
    assign w_unused_ok = ^DB_in[7:4];

endmodule

`default_nettype wire

// File: tb/tb_atari_7800.sv
// ============================================================================
// Module   : tb_atari_7800
// Brief    : Directed self-checking bench for the atari_7800 decoder/mapper.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_atari_7800;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] AB = 16'h0000;
    logic        RW = 1'b1;
    logic        cpu_ce = 1'b0;
    logic [7:0]  DB_in = 8'h00;
    logic        tia_mode = 1'b0;
    logic        bypass_bios = 1'b0;
    logic        hsc_en = 1'b0;
    logic [31:0] cart_size = 32'h8000;
    logic [15:0] cart_flags = 16'h0000;
    logic        cart_sel, bios_sel, tia_sel, maria_sel, riot_sel, ram_sel, hsc_sel;
    logic        tia_en, maria_en, locked;
    logic [18:0] cart_addr_out;

    int asserts = 0;
    int fails   = 0;

    wire [6:0] sel_vec = {tia_sel, maria_sel, ram_sel, riot_sel, bios_sel, hsc_sel, cart_sel};

    atari_7800 dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .AB            (AB),
        .RW            (RW),
        .cpu_ce        (cpu_ce),
        .DB_in         (DB_in),
        .tia_mode      (tia_mode),
        .bypass_bios   (bypass_bios),
        .hsc_en        (hsc_en),
        .cart_size     (cart_size),
        .cart_flags    (cart_flags),
        .cart_sel      (cart_sel),
        .cart_addr_out (cart_addr_out),
        .bios_sel      (bios_sel),
        .tia_sel       (tia_sel),
        .maria_sel     (maria_sel),
        .riot_sel      (riot_sel),
        .ram_sel       (ram_sel),
        .hsc_sel       (hsc_sel),
        .tia_en        (tia_en),
        .maria_en      (maria_en),
        .locked        (locked)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        AB = a; DB_in = d; RW = 1'b0; cpu_ce = 1'b1;
        @(posedge clk_sys); #1;
        cpu_ce = 1'b0; RW = 1'b1;
    endtask

    task automatic bus_read(input logic [15:0] a);
        AB = a; RW = 1'b1; cpu_ce = 1'b1;
        @(posedge clk_sys); #1;
        cpu_ce = 1'b0;
    endtask

    task automatic do_reset(input logic byp);
        bypass_bios = byp;
        #2 reset_n = 1'b0;
        #12 reset_n = 1'b1;
        @(posedge clk_sys); #1;
    endtask

    task automatic test_reset;
        tia_mode = 1'b0; cart_size = 32'h8000; cart_flags = 16'h0000;
        do_reset(1'b1);
        AB = 16'hFFFC; #1;
        asserts++;
        if ({tia_en, maria_en, locked} !== 3'b010) begin
            fails++; $display("FAIL reset_bypass_ctrl: got %b want 010", {tia_en, maria_en, locked});
        end
        asserts++;
        if ({bios_sel, cart_sel} !== 2'b01) begin
            fails++; $display("FAIL reset_bypass_sel: got %b want 01", {bios_sel, cart_sel});
        end
        do_reset(1'b0);
        AB = 16'hFFFC; #1;
        asserts++;
        if ({tia_en, maria_en, locked} !== 3'b000) begin
            fails++; $display("FAIL reset_ctrl: got %b want 000", {tia_en, maria_en, locked});
        end
        asserts++;
        if ({bios_sel, cart_sel} !== 2'b10) begin
            fails++; $display("FAIL reset_bios_sel: got %b want 10", {bios_sel, cart_sel});
        end
    endtask

    task automatic test_inptctrl;
        bus_write(16'h0001, 8'h07);
        AB = 16'hFFFC; #1;
        asserts++;
        if ({bios_sel, cart_sel, cart_addr_out} !== {2'b01, 19'h07FFC}) begin
            fails++; $display("FAIL inpt_write: got sel=%b addr=%h want sel=01 addr=07ffc",
                              {bios_sel, cart_sel}, cart_addr_out);
        end
        bus_write(16'h0001, 8'h02);
        AB = 16'hFFFC; #1;
        asserts++;
        if ({tia_en, maria_en, locked, bios_sel} !== 4'b0110) begin
            fails++; $display("FAIL inpt_locked: got %b want 0110", {tia_en, maria_en, locked, bios_sel});
        end
    endtask

    task automatic test_decode_7800;
        logic [15:0] v_ab  [0:12];
        logic [6:0]  v_sel [0:12];
        hsc_en = 1'b1;
        // order: tia, maria, ram, riot, bios, hsc, cart
        v_ab  = '{16'h0010, 16'h0030, 16'h0050, 16'h0150, 16'h2000, 16'h0290, 16'h0490,
                  16'h0100, 16'h1200, 16'h3500, 16'h4000, 16'hC000, 16'h001F};
`ifdef ATARI7800_HSC_EN
        v_sel = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0001000, 7'b0001000,
                  7'b0000000, 7'b0000010, 7'b0000010, 7'b0000000, 7'b0000001, 7'b1000000};
`else
        v_sel = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0001000, 7'b0001000,
                  7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b1000000};
`endif
        for (int i = 0; i < 13; i++) begin
            AB = v_ab[i]; #1;
            asserts++;
            if (sel_vec !== v_sel[i]) begin
                fails++; $display("FAIL decode_%h: got %b want %b", v_ab[i], sel_vec, v_sel[i]);
            end
        end
        hsc_en = 1'b0;
    endtask

    task automatic test_linear;
        cart_size = 32'h8000; cart_flags = 16'h0000;
        bus_read(16'h8123);
        asserts++;
        if ({cart_sel, cart_addr_out} !== {1'b1, 19'h00123}) begin
            fails++; $display("FAIL linear_8123: got sel=%b addr=%h want 1/00123", cart_sel, cart_addr_out);
        end
        AB = 16'h7FFF; #1;
        asserts++;
        if ({cart_sel, cart_addr_out} !== {1'b0, 19'h00123}) begin
            fails++; $display("FAIL linear_7fff: got sel=%b addr=%h want 0/00123", cart_sel, cart_addr_out);
        end
        cart_size = 32'h10000; AB = 16'h4000; #1;
        asserts++;
        if ({cart_sel, cart_addr_out} !== {1'b1, 19'h04000}) begin
            fails++; $display("FAIL linear_64k: got sel=%b addr=%h want 1/04000", cart_sel, cart_addr_out);
        end
    endtask

    task automatic test_supergame;
        cart_size = 32'h20000; cart_flags = 16'h000A;
        bus_write(16'h8000, 8'h03);
        AB = 16'h9000; #1;
        asserts++;
        if ({cart_sel, cart_addr_out} !== {1'b1, 19'h0D000}) begin
            fails++; $display("FAIL sg_bank: got sel=%b addr=%h want 1/0d000", cart_sel, cart_addr_out);
        end
        AB = 16'hC000; #1;
        asserts++;
        if (cart_addr_out !== 19'h1C000) begin
            fails++; $display("FAIL sg_last: got %h want 1c000", cart_addr_out);
        end
        AB = 16'h4000; #1;
        asserts++;
        if ({cart_sel, cart_addr_out} !== {1'b1, 19'h18000}) begin
            fails++; $display("FAIL sg_low: got sel=%b addr=%h want 1/18000", cart_sel, cart_addr_out);
        end
        cart_flags = 16'h0002; #1;
        asserts++;
        if (cart_sel !== 1'b0) begin
            fails++; $display("FAIL sg_low_off: got %b want 0", cart_sel);
        end
    endtask

    task automatic test_2600;
        tia_mode = 1'b1; cart_size = 32'd8192; cart_flags = 16'h0000;
        AB = 16'h0000; #1;
        asserts++;
        if ({tia_en, maria_en, tia_sel} !== 3'b101) begin
            fails++; $display("FAIL a26_ctrl: got %b want 101", {tia_en, maria_en, tia_sel});
        end
        bus_read(16'h1FF8);
        AB = 16'h1800; #1;
        asserts++;
        if ({cart_sel, cart_addr_out} !== {1'b1, 19'h00800}) begin
            fails++; $display("FAIL f8_bank0: got sel=%b addr=%h want 1/00800", cart_sel, cart_addr_out);
        end
        bus_read(16'h1FF9);
        AB = 16'h1800; #1;
        asserts++;
        if (cart_addr_out !== 19'h01800) begin
            fails++; $display("FAIL f8_bank1: got %h want 01800", cart_addr_out);
        end
        AB = 16'h0080; #1;
        asserts++;
        if (sel_vec !== 7'b0010000) begin
            fails++; $display("FAIL a26_ram: got %b want 0010000", sel_vec);
        end
        AB = 16'h0280; #1;
        asserts++;
        if (sel_vec !== 7'b0001000) begin
            fails++; $display("FAIL a26_riot: got %b want 0001000", sel_vec);
        end
        AB = 16'hF800; #1;
        asserts++;
        if ({sel_vec, cart_addr_out} !== {7'b0000001, 19'h01800}) begin
            fails++; $display("FAIL a26_upper: got sel=%b addr=%h want 0000001/01800", sel_vec, cart_addr_out);
        end
        cart_size = 32'd2048; AB = 16'h1ABC; #1;
        asserts++;
        if ({cart_sel, cart_addr_out} !== {1'b1, 19'h002BC}) begin
            fails++; $display("FAIL a26_2k: got sel=%b addr=%h want 1/002bc", cart_sel, cart_addr_out);
        end
    endtask

    task automatic test_async_reset;
        cart_size = 32'd8192;
        bus_read(16'h1FF8);
        AB = 16'h1800; #1;
        asserts++;
        if (cart_addr_out !== 19'h00800) begin
            fails++; $display("FAIL pre_f8: got %h want 00800", cart_addr_out);
        end
        tia_mode = 1'b0; cart_size = 32'h20000; cart_flags = 16'h000A;
        @(posedge clk_sys);
        #3 reset_n = 1'b0;
        #1;
        AB = 16'h9000; #1;
        asserts++;
        if (cart_addr_out !== 19'h01000) begin
            fails++; $display("FAIL async_sg_bank: got %h want 01000", cart_addr_out);
        end
        AB = 16'hFFFC; #1;
        asserts++;
        if ({maria_en, locked, bios_sel} !== 3'b001) begin
            fails++; $display("FAIL async_inpt: got %b want 001", {maria_en, locked, bios_sel});
        end
        tia_mode = 1'b1; cart_size = 32'd8192; AB = 16'h1800; #1;
        asserts++;
        if (cart_addr_out !== 19'h01800) begin
            fails++; $display("FAIL async_f8: got %h want 01800", cart_addr_out);
        end
        #10 reset_n = 1'b1;
        @(posedge clk_sys); #1;
    endtask

    initial begin
        test_reset;
        test_inptctrl;
        test_decode_7800;
        test_linear;
        test_supergame;
        test_2600;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

`default_nettype wire
